// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for a Sobel stage: two line buffers feed a column-shift array,
// one registered window per pixel. Optional registered border flag under SOBEL_WIN_EDGE_FLAG_EN.
module sobel_window_gen #(
   parameter int IMG_WIDTH  = 720,
   parameter int IMG_HEIGHT = 540,
   parameter int PIX_W      = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          in_empty,
   input  logic [PIX_W-1:0]              in_data,
   output logic                          in_rd_en,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [9*PIX_W-1:0]            window,
   output logic [$clog2(IMG_WIDTH)-1:0]  x,
`ifdef SOBEL_WIN_EDGE_FLAG_EN
   output logic [$clog2(IMG_HEIGHT)-1:0] y,
   output logic                          edge_flag
`else
   output logic [$clog2(IMG_HEIGHT)-1:0] y
`endif
);

   localparam int XW   = $clog2(IMG_WIDTH);
   localparam int YW   = $clog2(IMG_HEIGHT);
   localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int SW   = $clog2(NPIX + IMG_WIDTH + 1);

   localparam logic [SW-1:0] S_PRIME_LAST = SW'(IMG_WIDTH);
   localparam logic [SW-1:0] S_RUN_LAST   = SW'(NPIX - 1);
   localparam logic [SW-1:0] S_FLUSH_LAST = SW'(NPIX + IMG_WIDTH);
   localparam logic [XW-1:0] X_LAST       = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST       = YW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_t;

   state_t              state_reg, state_next;
   logic [SW-1:0]       s_reg;
   logic [XW-1:0]       cx_reg, cy_ptr_unused_guard;
   logic [YW-1:0]       cy_reg;
   logic [XW-1:0]       ptr_reg, ptr_next;
   logic                adv, shift, emit;
   logic [PIX_W-1:0]    new_pix;
   logic [PIX_W-1:0]    line0_mem [IMG_WIDTH];
   logic [PIX_W-1:0]    line1_mem [IMG_WIDTH];
   logic [PIX_W-1:0]    line0_rd, line1_rd;
   logic [9*PIX_W-1:0]  arr_reg, arr_next;

   assign cy_ptr_unused_guard = '0;
   assign adv = !out_valid || out_ready;

   // FSM output process: decides whether this cycle shifts and what enters the array
   always_comb begin
      in_rd_en = 1'b0;
      shift    = 1'b0;
      new_pix  = in_data;
      if (!reset && adv) begin
         case (state_reg)
            PRIME, RUN: begin
               if (!in_empty) begin
                  in_rd_en = 1'b1;
                  shift    = 1'b1;
               end
            end
            FLUSH: begin
               shift   = 1'b1;
               new_pix = '0;
            end
            default: ;
         endcase
      end
      emit = shift && (state_reg != PRIME);
   end

   always_comb begin
      state_next = state_reg;
      if (shift) begin
         case (state_reg)
            PRIME:   if (s_reg == S_PRIME_LAST) state_next = RUN;
            RUN:     if (s_reg == S_RUN_LAST)   state_next = FLUSH;
            FLUSH:   if (s_reg == S_FLUSH_LAST) state_next = PRIME;
            default: state_next = PRIME;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= PRIME;
      else       state_reg <= state_next;
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (reset)
         ptr_next = '0;
      else if (shift)
         ptr_next = (ptr_reg == X_LAST) ? '0 : ptr_reg + 1'b1;
   end

   // (cx, cy) wrap to (0, 0) naturally on the last flush output, ready for the next frame
   always_ff @(posedge clock) begin
      if (reset) begin
         s_reg   <= '0;
         cx_reg  <= '0;
         cy_reg  <= '0;
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
         if (shift)
            s_reg <= (state_reg == FLUSH && s_reg == S_FLUSH_LAST) ? '0 : s_reg + 1'b1;
         if (emit) begin
            if (cx_reg == X_LAST) begin
               cx_reg <= '0;
               cy_reg <= (cy_reg == Y_LAST) ? '0 : cy_reg + 1'b1;
            end else begin
               cx_reg <= cx_reg + 1'b1;
            end
         end
      end
   end

   // Read address tracks the next pointer, so the registered read always holds mem[ptr_reg]
   always_ff @(posedge clock) begin
      if (shift) begin
         line1_mem[ptr_reg] <= new_pix;
         line0_mem[ptr_reg] <= line1_rd;
      end
      line1_rd <= line1_mem[ptr_next];
      line0_rd <= line0_mem[ptr_next];
   end

   assign arr_next = {new_pix, line1_rd, line0_rd, arr_reg[9*PIX_W-1:3*PIX_W]};

   always_ff @(posedge clock) begin
      if (shift) arr_reg <= arr_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         window    <= '0;
         x         <= '0;
         y         <= '0;
`ifdef SOBEL_WIN_EDGE_FLAG_EN
         edge_flag <= 1'b0;
`endif
      end else if (emit) begin
         out_valid <= 1'b1;
         window    <= arr_next;
         x         <= cx_reg + cy_ptr_unused_guard;
         y         <= cy_reg;
`ifdef SOBEL_WIN_EDGE_FLAG_EN
         edge_flag <= (cx_reg == '0) || (cx_reg == X_LAST) || (cy_reg == '0) || (cy_reg == Y_LAST);
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen at 4x3: reset, streaming, stalls, bubbles, flush, mid-frame reset.
module tb_sobel_window_gen;

   localparam int W = 4;
   localparam int H = 3;
   localparam logic [71:0] WIN_F1_11 = 72'h0B0703_0A0602_090501;
   localparam logic [71:0] WIN_F1_21 = 72'h0C0804_0B0703_0A0602;
   localparam logic [71:0] WIN_F2_11 = 72'h17130F_16120E_15110D;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_empty = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        out_ready = 1'b1;
   logic        in_rd_en, out_valid;
   logic [71:0] window;
   logic [1:0]  x, y;
`ifdef SOBEL_WIN_EDGE_FLAG_EN
   logic        edge_flag;
`endif

   sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .clock(clock), .reset(reset), .in_empty(in_empty), .in_data(in_data),
      .in_rd_en(in_rd_en), .out_valid(out_valid), .out_ready(out_ready),
      .window(window), .x(x),
`ifdef SOBEL_WIN_EDGE_FLAG_EN
      .y(y), .edge_flag(edge_flag)
`else
      .y(y)
`endif
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  q[$];
   bit          pending_pop = 0;
   bit          bubble_en = 0;
   bit          ready_next = 1;
   bit          reset_next = 1;
   int          pops, cap_n, rd_viol;
   logic [1:0]  cap_x [32];
   logic [1:0]  cap_y [32];
   logic [71:0] cap_win [32];
   int          cap_pops [32];
   logic        cap_edge [32];

   // One clock: apply pending pop, drive inputs after the edge, observe at the falling edge
   task automatic tick();
      @(posedge clock);
      #1;
      if (pending_pop && q.size() > 0) q.delete(0);
      pending_pop = 0;
      reset     = reset_next;
      out_ready = ready_next;
      in_empty  = (q.size() == 0) || (bubble_en && $urandom_range(0, 1) == 1);
      in_data   = in_empty ? 8'hEE : q[0];
      @(negedge clock);
      if (!reset && out_valid && out_ready && cap_n < 32) begin
         cap_x[cap_n]    = x;
         cap_y[cap_n]    = y;
         cap_win[cap_n]  = window;
         cap_pops[cap_n] = pops;
`ifdef SOBEL_WIN_EDGE_FLAG_EN
         cap_edge[cap_n] = edge_flag;
`else
         cap_edge[cap_n] = 1'b0;
`endif
         $display("out %0d: x=%0d y=%0d win=%h pops=%0d", cap_n, x, y, window, pops);
         cap_n++;
      end
      if (in_rd_en) begin
         pops++;
         pending_pop = !in_empty;
         if (in_empty) rd_viol++;
      end
   endtask

   task automatic clear_capture();
      cap_n = 0;
      pops = 0;
      rd_viol = 0;
   endtask

   task automatic push_frame(input int base);
      for (int i = 0; i < W * H; i++) q.push_back(8'(base + i));
   endtask

   task automatic run_frame(input int budget);
      int n = 0;
      while (cap_n < W * H && n < budget) begin
         tick();
         n++;
      end
      repeat (10) tick();
   endtask

   task automatic test_reset();
      reset_next = 1;
      q.push_back(8'h55);
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (in_empty !== 1'b0 || in_rd_en !== 1'b0 || out_valid !== 1'b0 || window !== '0 || x !== '0 || y !== '0) begin
            errors++;
            $display("FAIL reset cycle %0d: rd_en=%b valid=%b window=%h x=%0d y=%0d, required rd_en=0 valid=0 window=0 x=0 y=0 (in_empty=%b)",
                     c, in_rd_en, out_valid, window, x, y, in_empty);
         end
      end
      q.delete();
      reset_next = 0;
      tick();
   endtask

   task automatic test_stream();
      clear_capture();
      push_frame(1);
      run_frame(100);
      checks++;
      if (cap_n !== 12) begin errors++; $display("FAIL stream count: got %0d required 12", cap_n); end
      checks++;
      if (cap_pops[0] !== 6) begin errors++; $display("FAIL stream first-output latency: after pop %0d required 6", cap_pops[0]); end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (cap_x[i] !== 2'(i % W) || cap_y[i] !== 2'(i / W)) begin
            errors++;
            $display("FAIL stream coord %0d: got (%0d,%0d) required (%0d,%0d)", i, cap_x[i], cap_y[i], i % W, i / W);
         end
      end
      checks++;
      if (cap_win[5] !== WIN_F1_11) begin errors++; $display("FAIL stream window(1,1): got %h required %h", cap_win[5], WIN_F1_11); end
      checks++;
      if (cap_win[6] !== WIN_F1_21) begin errors++; $display("FAIL stream window(2,1): got %h required %h", cap_win[6], WIN_F1_21); end
      checks++;
      if (rd_viol !== 0) begin errors++; $display("FAIL stream rd_en while empty: got %0d required 0", rd_viol); end
   endtask

   task automatic test_stall();
      logic [71:0] sw;
      logic [1:0]  sx, sy;
      int n = 0;
      clear_capture();
      push_frame(1);
      while (cap_n < 3 && n < 50) begin tick(); n++; end
      ready_next = 0;
      tick();
      sw = window; sx = x; sy = y;
      checks++;
      if (out_valid !== 1'b1 || sx !== 2'd3 || sy !== 2'd0) begin
         errors++;
         $display("FAIL stall presented: valid=%b x=%0d y=%0d required valid=1 x=3 y=0", out_valid, sx, sy);
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (in_rd_en !== 1'b0 || out_valid !== 1'b1 || window !== sw || x !== sx || y !== sy) begin
            errors++;
            $display("FAIL stall hold %0d: rd_en=%b valid=%b x=%0d y=%0d window=%h required rd_en=0 valid=1 x=%0d y=%0d window=%h",
                     c, in_rd_en, out_valid, x, y, window, sx, sy, sw);
         end
         if (c < 4) tick();
      end
      ready_next = 1;
      run_frame(100);
      checks++;
      if (cap_n !== 12) begin errors++; $display("FAIL stall count: got %0d required 12", cap_n); end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (cap_x[i] !== 2'(i % W) || cap_y[i] !== 2'(i / W)) begin
            errors++;
            $display("FAIL stall coord %0d: got (%0d,%0d) required (%0d,%0d)", i, cap_x[i], cap_y[i], i % W, i / W);
         end
      end
      checks++;
      if (cap_win[5] !== WIN_F1_11 || cap_win[6] !== WIN_F1_21) begin
         errors++;
         $display("FAIL stall windows: got %h %h required %h %h", cap_win[5], cap_win[6], WIN_F1_11, WIN_F1_21);
      end
   endtask

   task automatic test_bubbles();
      clear_capture();
      bubble_en = 1;
      push_frame(1);
      run_frame(400);
      bubble_en = 0;
      checks++;
      if (cap_n !== 12) begin errors++; $display("FAIL bubbles count: got %0d required 12", cap_n); end
      checks++;
      if (cap_pops[0] !== 6) begin errors++; $display("FAIL bubbles first-output latency: after pop %0d required 6", cap_pops[0]); end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (cap_x[i] !== 2'(i % W) || cap_y[i] !== 2'(i / W)) begin
            errors++;
            $display("FAIL bubbles coord %0d: got (%0d,%0d) required (%0d,%0d)", i, cap_x[i], cap_y[i], i % W, i / W);
         end
      end
      checks++;
      if (cap_win[5] !== WIN_F1_11 || cap_win[6] !== WIN_F1_21) begin
         errors++;
         $display("FAIL bubbles windows: got %h %h required %h %h", cap_win[5], cap_win[6], WIN_F1_11, WIN_F1_21);
      end
      checks++;
      if (rd_viol !== 0) begin errors++; $display("FAIL bubbles rd_en while empty: got %0d required 0", rd_viol); end
   endtask

   task automatic test_flush_next_frame();
      clear_capture();
      push_frame(1);
      run_frame(100);
      checks++;
      if (cap_n !== 12) begin errors++; $display("FAIL flush count: got %0d required 12", cap_n); end
      for (int i = 7; i < 12; i++) begin
         checks++;
         if (cap_pops[i] !== 12 || cap_x[i] !== 2'(i % W) || cap_y[i] !== 2'(i / W)) begin
            errors++;
            $display("FAIL flush output %0d: pops=%0d x=%0d y=%0d required pops=12 x=%0d y=%0d",
                     i, cap_pops[i], cap_x[i], cap_y[i], i % W, i / W);
         end
      end
      checks++;
      if (rd_viol !== 0) begin errors++; $display("FAIL flush rd_en while empty: got %0d required 0", rd_viol); end
      clear_capture();
      push_frame(13);
      run_frame(100);
      checks++;
      if (cap_n !== 12) begin errors++; $display("FAIL frame2 count: got %0d required 12", cap_n); end
      checks++;
      if (cap_pops[0] !== 6) begin errors++; $display("FAIL frame2 first-output latency: after pop %0d required 6", cap_pops[0]); end
      checks++;
      if (cap_win[5] !== WIN_F2_11 || cap_x[5] !== 2'd1 || cap_y[5] !== 2'd1) begin
         errors++;
         $display("FAIL frame2 window(1,1): got %h at (%0d,%0d) required %h at (1,1)", cap_win[5], cap_x[5], cap_y[5], WIN_F2_11);
      end
   endtask

   task automatic test_reset_mid_frame();
      int n = 0;
      clear_capture();
      push_frame(1);
      while (pops < 7 && n < 50) begin tick(); n++; end
      checks++;
      if (pops !== 7) begin errors++; $display("FAIL midreset pops before reset: got %0d required 7", pops); end
      reset_next = 1;
      tick();
      tick();
      q.delete();
      push_frame(1);
      clear_capture();
      reset_next = 0;
      run_frame(100);
      checks++;
      if (cap_n !== 12) begin errors++; $display("FAIL midreset count: got %0d required 12", cap_n); end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (cap_x[i] !== 2'(i % W) || cap_y[i] !== 2'(i / W)) begin
            errors++;
            $display("FAIL midreset coord %0d: got (%0d,%0d) required (%0d,%0d)", i, cap_x[i], cap_y[i], i % W, i / W);
         end
`ifdef SOBEL_WIN_EDGE_FLAG_EN
         checks++;
         if (cap_edge[i] !== ((i == 5 || i == 6) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL midreset edge %0d: got %b required %b", i, cap_edge[i], (i == 5 || i == 6) ? 1'b0 : 1'b1);
         end
`endif
      end
      checks++;
      if (cap_win[5] !== WIN_F1_11 || cap_win[6] !== WIN_F1_21) begin
         errors++;
         $display("FAIL midreset windows: got %h %h required %h %h", cap_win[5], cap_win[6], WIN_F1_11, WIN_F1_21);
      end
   endtask

   initial begin
      clear_capture();
      test_reset();
      test_stream();
      test_stall();
      test_bubbles();
      test_flush_next_frame();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
